multicycle_control_fsm: RTL and testbench

Main control state machine for the multicycle nachi datapath. It decodes the 6-bit instruction opcode over several clock cycles and drives every datapath enable and mux select. It also produces the 2-bit ALU operation class that the ALU decoder consumes. It sequences fetch, decode, execute, memory and write-back, and stalls on a memory ready handshake.

---
 rtl/nachi_pkg.sv | 40 ++++
 rtl/control_output_decode.sv | 100 ++++++++++
 rtl/multicycle_control_fsm.sv | 91 +++++++++
 tb/tb_multicycle_control_fsm.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/nachi_pkg.sv
// Shared definitions for the nachi multicycle datapath control: state encoding,
// opcodes and the mux / ALU select constants driven by the controller.
package nachi_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_SEXT  = 2'b10;
  localparam logic [1:0] SRCB_SHIFT = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/control_output_decode.sv
// Combinational map from controller state (plus mem_ready / zero qualifiers)
// to every datapath enable and mux select.
module control_output_decode
  import nachi_pkg::*;
(
  input  state_t     state,
  input  logic       reset,
  input  logic       mem_ready,
  input  logic       zero,
  output logic       mem_req,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_en,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       iord,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [1:0] alu_op
);

  logic pc_write;
  logic branch;
  logic req_raw;
  logic wr_raw;
  logic ir_raw;
  logic rf_raw;

  always_comb begin
    req_raw    = 1'b0;
    wr_raw     = 1'b0;
    ir_raw     = 1'b0;
    rf_raw     = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    iord       = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    pc_src     = PCSRC_ALU;
    alu_op     = ALU_ADD;
    unique case (state)
      S_FETCH: begin
        req_raw   = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_raw    = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: alu_src_b = SRCB_SHIFT;
      S_MEMADR, S_ADDIEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_SEXT;
      end
      S_MEMRD: begin
        req_raw = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWR: begin
        req_raw = 1'b1;
        iord    = 1'b1;
        wr_raw  = 1'b1;
      end
      S_MEMWB: begin
        rf_raw     = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        rf_raw  = 1'b1;
        reg_dst = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = PCSRC_ALUOUT;
        branch    = 1'b1;
      end
      S_ADDIWB: rf_raw = 1'b1;
      S_JUMP: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset suppresses every write and the memory request without waiting for a clock edge.
  assign mem_req   = req_raw & ~reset;
  assign mem_write = wr_raw & ~reset;
  assign ir_write  = ir_raw & ~reset;
  assign reg_write = rf_raw & ~reset;
  assign pc_en     = (pc_write | (branch & zero)) & ~reset;

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main multicycle controller: state register, opcode-driven next-state logic,
// and the combinational output decoder.
module multicycle_control_fsm
  import nachi_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_en,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       iord,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [1:0] alu_op,
  output logic       illegal
);

  state_t state;
  state_t state_nxt;
  logic   is_store;
  logic   is_store_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_FETCH;
      is_store <= 1'b0;
    end else begin
      state    <= state_nxt;
      is_store <= is_store_nxt;
    end
  end

  // The lw/sw distinction is captured in DECODE so MEMADR ignores later opcode changes.
  always_comb begin
    state_nxt    = state;
    is_store_nxt = is_store;
    illegal      = 1'b0;
    unique case (state)
      S_FETCH: if (mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        is_store_nxt = (opcode == OP_SW);
        case (opcode)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYPE:     state_nxt = S_EXECUTE;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_ADDI:      state_nxt = S_ADDIEXEC;
          OP_J:         state_nxt = S_JUMP;
          default: begin
            state_nxt = S_FETCH;
            illegal   = 1'b1;
          end
        endcase
      end
      S_MEMADR:   state_nxt = is_store ? S_MEMWR : S_MEMRD;
      S_MEMRD:    if (mem_ready) state_nxt = S_MEMWB;
      S_MEMWR:    if (mem_ready) state_nxt = S_FETCH;
      S_EXECUTE:  state_nxt = S_ALUWB;
      S_ADDIEXEC: state_nxt = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: state_nxt = S_FETCH;
      default:    state_nxt = S_FETCH;
    endcase
  end

  control_output_decode u_dec (
    .state      (state),
    .reset      (reset),
    .mem_ready  (mem_ready),
    .zero       (zero),
    .mem_req    (mem_req),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .pc_en      (pc_en),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .iord       (iord),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_src     (pc_src),
    .alu_op     (alu_op)
  );

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: walks each instruction class cycle by
// cycle and compares the full output vector against hand-computed constants.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'h00;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       mem_req, mem_write, ir_write, pc_en, reg_write, reg_dst;
  logic       mem_to_reg, iord, alu_src_a, illegal;
  logic [1:0] alu_src_b, pc_src, alu_op;

  int compared = 0;
  int mismatched = 0;

  // Vector layout: mem_req,mem_write,ir_write,pc_en,reg_write,reg_dst,mem_to_reg,
  // iord,alu_src_a,alu_src_b[1:0],pc_src[1:0],alu_op[1:0],illegal
  localparam logic [15:0] V_RST      = 16'h0020;
  localparam logic [15:0] V_FETCH    = 16'hB020;
  localparam logic [15:0] V_FETCHW   = 16'h8020;
  localparam logic [15:0] V_DECODE   = 16'h0060;
  localparam logic [15:0] V_ILLEGAL  = 16'h0061;
  localparam logic [15:0] V_MEMADR   = 16'h00C0;
  localparam logic [15:0] V_MEMRD    = 16'h8100;
  localparam logic [15:0] V_MEMWR    = 16'hC100;
  localparam logic [15:0] V_MEMWB    = 16'h0A00;
  localparam logic [15:0] V_EXECUTE  = 16'h0084;
  localparam logic [15:0] V_ALUWB    = 16'h0C00;
  localparam logic [15:0] V_BRTAKEN  = 16'h108A;
  localparam logic [15:0] V_BRNOT    = 16'h008A;
  localparam logic [15:0] V_ADDIEXEC = 16'h00C0;
  localparam logic [15:0] V_ADDIWB   = 16'h0800;
  localparam logic [15:0] V_JUMP     = 16'h1010;

  wire [15:0] obs = {mem_req, mem_write, ir_write, pc_en, reg_write, reg_dst,
                     mem_to_reg, iord, alu_src_a, alu_src_b, pc_src, alu_op, illegal};

  multicycle_control_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .pc_en      (pc_en),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .iord       (iord),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_src     (pc_src),
    .alu_op     (alu_op),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $display("FAIL %s observed=%04h expected=%04h", tag, obs, expv);
      $error("output vector differs at %s", tag);
    end
  endtask

  // One controller cycle: drive on the falling edge, compare 1 time unit later.
  task automatic cyc(input string tag, input logic r, input logic rdy, input logic z,
                     input logic [5:0] op, input logic [15:0] expv);
    @(negedge clk);
    reset     = r;
    mem_ready = rdy;
    zero      = z;
    opcode    = op;
    #1;
    check(tag, expv);
  endtask

  initial begin
    // Reset for three cycles, then an R-type instruction
    cyc("rst0", 1'b1, 1'b1, 1'b0, 6'h00, V_RST);
    cyc("rst1", 1'b1, 1'b1, 1'b0, 6'h00, V_RST);
    cyc("rst2", 1'b1, 1'b1, 1'b0, 6'h00, V_RST);
    cyc("r_fetch",   1'b0, 1'b1, 1'b0, 6'h00, V_FETCH);
    cyc("r_decode",  1'b0, 1'b1, 1'b0, 6'h00, V_DECODE);
    cyc("r_execute", 1'b0, 1'b1, 1'b0, 6'h00, V_EXECUTE);
    cyc("r_aluwb",   1'b0, 1'b1, 1'b0, 6'h00, V_ALUWB);

    // lw with a fetch stall and two MEMRD wait cycles
    cyc("lw_fetchw",  1'b0, 1'b0, 1'b0, 6'h23, V_FETCHW);
    cyc("lw_fetch",   1'b0, 1'b1, 1'b0, 6'h23, V_FETCH);
    cyc("lw_decode",  1'b0, 1'b0, 1'b0, 6'h23, V_DECODE);
    cyc("lw_memadr",  1'b0, 1'b1, 1'b0, 6'h00, V_MEMADR);
    cyc("lw_memrd0",  1'b0, 1'b0, 1'b0, 6'h00, V_MEMRD);
    cyc("lw_memrd1",  1'b0, 1'b0, 1'b0, 6'h00, V_MEMRD);
    cyc("lw_memrd2",  1'b0, 1'b1, 1'b0, 6'h00, V_MEMRD);
    cyc("lw_memwb",   1'b0, 1'b1, 1'b0, 6'h00, V_MEMWB);

    // sw; opcode changed to lw after DECODE must not redirect to MEMRD
    cyc("sw_fetch",   1'b0, 1'b1, 1'b0, 6'h2B, V_FETCH);
    cyc("sw_decode",  1'b0, 1'b1, 1'b0, 6'h2B, V_DECODE);
    cyc("sw_memadr",  1'b0, 1'b1, 1'b0, 6'h23, V_MEMADR);
    cyc("sw_memwr0",  1'b0, 1'b0, 1'b0, 6'h23, V_MEMWR);
    cyc("sw_memwr1",  1'b0, 1'b1, 1'b0, 6'h23, V_MEMWR);

    // beq taken, then not taken
    cyc("beq1_fetch",  1'b0, 1'b1, 1'b0, 6'h04, V_FETCH);
    cyc("beq1_decode", 1'b0, 1'b1, 1'b0, 6'h04, V_DECODE);
    cyc("beq1_branch", 1'b0, 1'b1, 1'b1, 6'h04, V_BRTAKEN);
    cyc("beq0_fetch",  1'b0, 1'b1, 1'b0, 6'h04, V_FETCH);
    cyc("beq0_decode", 1'b0, 1'b1, 1'b1, 6'h04, V_DECODE);
    cyc("beq0_branch", 1'b0, 1'b1, 1'b0, 6'h04, V_BRNOT);

    // addi and j
    cyc("addi_fetch", 1'b0, 1'b1, 1'b0, 6'h08, V_FETCH);
    cyc("addi_decode",1'b0, 1'b1, 1'b0, 6'h08, V_DECODE);
    cyc("addi_exec",  1'b0, 1'b1, 1'b0, 6'h08, V_ADDIEXEC);
    cyc("addi_wb",    1'b0, 1'b1, 1'b0, 6'h08, V_ADDIWB);
    cyc("j_fetch",    1'b0, 1'b1, 1'b0, 6'h02, V_FETCH);
    cyc("j_decode",   1'b0, 1'b1, 1'b0, 6'h02, V_DECODE);
    cyc("j_jump",     1'b0, 1'b1, 1'b0, 6'h02, V_JUMP);

    // Unrecognised opcode: one illegal pulse, straight back to FETCH
    cyc("ill_fetch",  1'b0, 1'b1, 1'b0, 6'h3F, V_FETCH);
    cyc("ill_decode", 1'b0, 1'b1, 1'b0, 6'h3F, V_ILLEGAL);
    cyc("ill_after",  1'b0, 1'b0, 1'b0, 6'h3F, V_FETCHW);

    // Asynchronous reset in the middle of a stalled MEMWR
    cyc("ar_fetch",  1'b0, 1'b1, 1'b0, 6'h2B, V_FETCH);
    cyc("ar_decode", 1'b0, 1'b1, 1'b0, 6'h2B, V_DECODE);
    cyc("ar_memadr", 1'b0, 1'b1, 1'b0, 6'h2B, V_MEMADR);
    cyc("ar_memwr",  1'b0, 1'b0, 1'b0, 6'h2B, V_MEMWR);
    #2;
    reset = 1'b1;
    #1;
    check("ar_async", V_RST);
    cyc("ar_hold",    1'b1, 1'b0, 1'b0, 6'h00, V_RST);
    cyc("ar_fetch2",  1'b0, 1'b1, 1'b0, 6'h00, V_FETCH);
    cyc("ar_decode2", 1'b0, 1'b1, 1'b0, 6'h00, V_DECODE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
